// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: valid/ready front end for a single-port RAM with a whole-memory fill engine.
module ram_access_ctrl #(
  parameter int Data_width = 32,
  parameter int Addr_width = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_start,
  input  logic [Data_width-1:0] init_value,
  output logic                  init_busy,
  output logic                  init_done,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [Addr_width-1:0] req_addr,
  input  logic [Data_width-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [Data_width-1:0] rsp_rdata,
  output logic                  ram_we,
  output logic [Addr_width-1:0] ram_address,
  output logic [Data_width-1:0] ram_d,
  input  logic [Data_width-1:0] ram_q
);
  typedef enum logic {IDLE, FILL} state_t;
  state_t                state_q, state_d;
  logic [Addr_width-1:0] cnt_q, cnt_d;
  logic [Data_width-1:0] fill_q, fill_d, rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_valid_q, rsp_valid_d, init_done_q, init_done_d;
  logic                  acc, rd_acc, last;
  // gated by rst_n so nothing reaches the RAM while reset is held
  assign req_ready   = rst_n && state_q == IDLE && !init_start && (!rsp_valid_q || rsp_ready);
  assign acc         = req_valid && req_ready;
  assign rd_acc      = acc && !req_we;
  assign last        = &cnt_q;
  assign ram_we      = rst_n && (state_q == FILL || (acc && req_we));
  assign ram_address = state_q == FILL ? cnt_q : req_addr;
  assign ram_d       = state_q == FILL ? fill_q : req_wdata;
  assign init_busy   = state_q == FILL;
  assign init_done   = init_done_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  always_comb begin
    state_d     = state_q == IDLE ? (init_start ? FILL : IDLE) : (last ? IDLE : FILL);
    cnt_d       = state_q == FILL ? cnt_q + 1'b1 : '0;
    fill_d      = state_q == IDLE && init_start ? init_value : fill_q;
    init_done_d = state_q == FILL && last;
    rsp_valid_d = rd_acc || (rsp_valid_q && !rsp_ready);
    rsp_rdata_d = rd_acc ? ram_q : rsp_rdata_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      fill_q      <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
endmodule
